digit_serial_addsub: RTL and testbench
======================================

# digit_serial_addsub

Parametrised digit-serial adder/subtractor: the generalisation of the team's bit-serial carry-shifting adder. It processes `D` bits per clock over an `N`-bit word, so it trades area for latency. It supports add and subtract-with-borrow modes and reports signed overflow and zero. It is used in the FPU datapath wherever a narrow, multi-cycle integer add/sub (exponent and mantissa adjust) is acceptable.

## Interface
Parameters:
- `N`, default 8: operand width in bits. Must be ≥ 2.
- `D`, default 1: digit width (bits processed per cycle). `N % D == 0` is required; elaboration fails otherwise.

Ports:
- `CLOCK_50`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request. Sampled only when `busy == 0`.
- `A`, input, N: operand A. Captured on the accepting edge.
- `B`, input, N: operand B. Captured on the accepting edge.
- `Cin`, input, 1: carry-in when `sub=0`; borrow-in when `sub=1`. Captured on the accepting edge.
- `sub`, input, 1: 0 gives A+B+Cin; 1 gives A−B−Cin. Captured on the accepting edge.
- `S`, output, N: result. Holds until the next completion.
- `Cout`, output, 1: carry-out. In subtract mode, 1 means no borrow.
- `ovf`, output, 1: two's-complement signed overflow.
- `zero`, output, 1: `S == 0`.
- `busy`, output, 1: operation in flight.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE → RUN when `start` is sampled high.
  - RUN → IDLE when the digit counter reaches K−1, where K = N/D.
- Accept (IDLE and `start`):
  - load `A_reg=A` and `B_reg = sub ? ~B : B`;
  - `carry = Cin ^ sub`;
  - `count = 0`; clear `S_reg`.
- Each RUN cycle:
  - the digit adder sums `A_reg[D-1:0]`, `B_reg[D-1:0]` and `carry`;
  - the D-bit sum is shifted into `S_reg` from the MSB side;
  - `A_reg` and `B_reg` shift right by D with zero fill;
  - `carry` takes the digit carry-out;
  - `count` increments.
- Final digit:
  - `S = {digit_sum, S_reg[N-1:D]}`;
  - `Cout` = digit carry-out;
  - `ovf` = carry into bit N−1 XOR carry out of bit N−1, taken from inside the digit adder;
  - `zero = (S == 0)`;
  - `done` is pulsed;
  - return to IDLE.
- `start` is ignored while `busy`. No queuing.
- Operand inputs are don't-care outside the accepting edge.
- Arithmetic is modulo 2^N. There is no saturation.
- Reset (async, at any time, including mid-operation):
  - all internal registers clear;
  - outputs `S=0`, `Cout=0`, `ovf=0`, `zero=0`, `busy=0`, `done=0`;
  - the in-flight operation is discarded with no `done`.
- After reset deasserts, the first rising edge with `start=1` is accepted.

## Timing
- Call the accepting edge E0.
  - `busy` = 1 from E0 up to E0+K.
  - `S`, `Cout`, `ovf` and `zero` update at E0+K.
  - `done` = 1 for exactly the cycle following E0+K.
- Latency is K = N/D cycles. N=8, D=1 gives 8; D=4 gives 2; D=N gives 1.
- `start` high at edge E0+K is ignored, because `busy` is still 1 when sampled. The next accept is at E0+K+1 at the earliest.
- Maximum throughput is one operation per K+1 cycles.
- `done` and `busy` are never high in the same cycle.
- Result outputs remain stable between completions.

## Structure
- Shared package `fpu_pkg`:
  - FSM state encoding (`ST_IDLE`, `ST_RUN`);
  - a `clog2`-based counter-width helper.
- One sub-module, `digit_adder #(D)`:
  - combinational D-bit ripple of the existing `full_adder`;
  - outputs `sum[D-1:0]`, `cout`, `c_msb_in` (carry into its top bit, used for `ovf`).
- Top level contains the FSM, shift registers, counter and output registers.

## Test plan
- N=8, D=1, sub=0: A=0x5A, B=0x3C, Cin=0 → after 8 cycles S=0x96, Cout=0, ovf=1, zero=0. `done` pulses exactly once, in the cycle after edge E0+8.
- N=8, D=1, sub=1: A=0x10, B=0x20, Cin=0 → S=0xF0, Cout=0 (borrow), ovf=0. Also sub=1, A=0x20, B=0x10, Cin=1 → S=0x0F, Cout=1.
- N=8, D=4: A=0xFF, B=0x01, Cin=0, sub=0 → after 2 cycles S=0x00, Cout=1, zero=1, ovf=0. Also A=0x7F, B=0x00, Cin=1 → S=0x80, ovf=1.
- `start` held high continuously with N=8, D=1 and changing operands → accepts spaced exactly 9 cycles apart. Operands presented mid-operation are ignored and results match only the accepted operands.
- `rst` pulsed at cycle 4 of a run → all outputs go to 0 immediately, no `done`. A new `start` after release completes correctly.
- Sweep D ∈ {1,2,4,8} at N=8 with 1000 random A/B/Cin/sub → S, Cout and ovf match a reference model, and latency equals N/D.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the serial FPU datapath units: FSM encoding and sizing helpers.
package fpu_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Counter width able to hold 0..depth-1, never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational D-bit ripple adder; also exposes the carry into its top bit for overflow detection.
module digit_adder #(
  parameter int D = 1
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [D:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < D; i++) begin : g_fa
    full_adder u_fa (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_c[i]),
      .o_s (sum[i]),
      .o_c (w_c[i+1])
    );
  end

  assign cout     = w_c[D];
  assign c_msb_in = w_c[D-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used as the ripple element of the serial adders.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial N-bit adder/subtractor: D bits per clock, K = N/D cycles per operation,
// with carry-out, signed overflow and zero flags registered at completion.
module digit_serial_addsub
  import fpu_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         CLOCK_50,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         ovf,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam int              K          = N / D;
  localparam int              CW         = cnt_width(K);
  localparam logic [CW-1:0]   LAST_DIGIT = CW'(K - 1);

  if (N < 2 || D < 1 || (N % D) != 0) begin : g_bad_params
    $error("digit_serial_addsub: N must be >= 2 and an exact multiple of D");
  end

  logic [0:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_s;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  logic [D-1:0]  w_sum;
  logic          w_cout;
  logic          w_c_msb;
  logic [N-1:0]  w_s_next;

  digit_adder #(.D(D)) u_digit (
    .a        (r_a[D-1:0]),
    .b        (r_b[D-1:0]),
    .cin      (r_carry),
    .sum      (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_c_msb)
  );

  // New digit enters from the MSB side; the oldest D bits fall off the bottom.
  assign w_s_next = N'({w_sum, r_s} >> D);
  assign busy     = (r_state == ST_RUN);

  // NOTE: every register here is written with <= so all of them sample pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + ~borrow, so the borrow-in is inverted into the carry.
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= Cin ^ sub;
            r_cnt   <= '0;
            r_s     <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> D;
          r_b     <= r_b >> D;
          r_carry <= w_cout;
          r_s     <= w_s_next;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_DIGIT) begin
            S       <= w_s_next;
            Cout    <= w_cout;
            ovf     <= w_c_msb ^ w_cout;
            zero    <= (w_s_next == '0);
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub: four instances at N=8 with D = 1, 2, 4, 8.
module tb_digit_serial_addsub;

  localparam int NI = 4;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_i [NI];
  logic [7:0] a_i     [NI];
  logic [7:0] b_i     [NI];
  logic       cin_i   [NI];
  logic       sub_i   [NI];
  logic [7:0] s_o     [NI];
  logic       cout_o  [NI];
  logic       ovf_o   [NI];
  logic       zero_o  [NI];
  logic       busy_o  [NI];
  logic       done_o  [NI];

  exp_t q        [NI][$];
  exp_t hold     [NI];
  int   last_acc [NI];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    digit_serial_addsub #(.N(8), .D(1 << g)) u_dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .start    (start_i[g]),
      .A        (a_i[g]),
      .B        (b_i[g]),
      .Cin      (cin_i[g]),
      .sub      (sub_i[g]),
      .S        (s_o[g]),
      .Cout     (cout_o[g]),
      .ovf      (ovf_o[g]),
      .zero     (zero_o[g]),
      .busy     (busy_o[g]),
      .done     (done_o[g])
    );
  end

  function automatic int lat(input int i);
    return 8 >> i;
  endfunction

  function automatic exp_t mk(input logic [7:0] s, input logic cout, input logic ovf, input logic zero);
    exp_t e;
    e.s = s; e.cout = cout; e.ovf = ovf; e.zero = zero; e.acc = 0;
    return e;
  endfunction

  // Reference: plain integer arithmetic, unsigned for S/Cout and signed for overflow.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    exp_t e;
    int ua, ub, sa, sb, c, r, sr;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); c = cin;
    if (!sub) begin
      r = ua + ub + c; sr = sa + sb + c; e.cout = (r > 255);
    end else begin
      r = ua - ub - c; sr = sa - sb - c; e.cout = (r >= 0);
    end
    e.s    = r[7:0];
    e.ovf  = (sr > 127) || (sr < -128);
    e.zero = (e.s == 8'h00);
    e.acc  = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; waits until the instance model is free, then presents one request.
  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input exp_t e);
    while (cyc + 1 < last_acc[i] + lat(i) + 1) @(negedge clk);
    start_i[i] = 1'b1; a_i[i] = a; b_i[i] = b; cin_i[i] = cin; sub_i[i] = sub;
    e.acc       = cyc + 1;
    last_acc[i] = e.acc;
    q[i].push_back(e);
    @(negedge clk);
    start_i[i] = 1'b0;
    a_i[i] = 8'($urandom); b_i[i] = 8'($urandom);
    cin_i[i] = 1'($urandom); sub_i[i] = 1'($urandom);
  endtask

  task automatic drive_rand(input int i, input int n);
    logic [7:0] a, b;
    logic       cin, sub;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      issue(i, a, b, cin, sub, model(a, b, cin, sub));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_S[%0d]", tag, i), s_o[i], 0);
      check($sformatf("%s_Cout[%0d]", tag, i), cout_o[i], 0);
      check($sformatf("%s_ovf[%0d]", tag, i), ovf_o[i], 0);
      check($sformatf("%s_zero[%0d]", tag, i), zero_o[i], 0);
      check($sformatf("%s_busy[%0d]", tag, i), busy_o[i], 0);
      check($sformatf("%s_done[%0d]", tag, i), done_o[i], 0);
    end
  endtask

  // Monitor: busy window, completion results, latency, and output hold between completions.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        k = lat(i);
        check($sformatf("busy[%0d]", i), busy_o[i],
              (cyc >= last_acc[i]) && (cyc < last_acc[i] + k));
        if (done_o[i]) begin
          if (q[i].size() == 0) begin
            check($sformatf("unexpected_done[%0d]", i), 1, 0);
          end else begin
            e = q[i].pop_front();
            check($sformatf("S[%0d]", i), s_o[i], e.s);
            check($sformatf("Cout[%0d]", i), cout_o[i], e.cout);
            check($sformatf("ovf[%0d]", i), ovf_o[i], e.ovf);
            check($sformatf("zero[%0d]", i), zero_o[i], e.zero);
            check($sformatf("latency[%0d]", i), cyc - e.acc, k);
            hold[i] = e;
          end
        end else begin
          check($sformatf("hold[%0d]", i), {s_o[i], cout_o[i], ovf_o[i], zero_o[i]},
                {hold[i].s, hold[i].cout, hold[i].ovf, hold[i].zero});
        end
      end
    end
  end

  initial begin
    exp_t       e;
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         pend;

    for (int i = 0; i < NI; i++) begin
      start_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0; cin_i[i] = 1'b0; sub_i[i] = 1'b0;
      last_acc[i] = -100;
      hold[i] = mk(8'h00, 1'b0, 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases with hand-computed results.
    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0, mk(8'h96, 1'b0, 1'b1, 1'b0));
    issue(0, 8'h10, 8'h20, 1'b0, 1'b1, mk(8'hF0, 1'b0, 1'b0, 1'b0));
    issue(0, 8'h20, 8'h10, 1'b1, 1'b1, mk(8'h0F, 1'b1, 1'b0, 1'b0));
    issue(2, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1));
    issue(2, 8'h7F, 8'h00, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0));
    issue(3, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1, 1'b0));
    issue(1, 8'h7F, 8'h7F, 1'b1, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    repeat (10) @(negedge clk);

    // start held high with operands changing every cycle: only K+1-spaced accepts count.
    start_i[0] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      a_i[0] = ra; b_i[0] = rb; cin_i[0] = rc; sub_i[0] = rs;
      if (cyc + 1 >= last_acc[0] + lat(0) + 1) begin
        e = model(ra, rb, rc, rs);
        e.acc = cyc + 1;
        last_acc[0] = e.acc;
        q[0].push_back(e);
      end
      @(negedge clk);
    end
    start_i[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of the fourth RUN cycle.
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      last_acc[i] = -100;
      hold[i] = mk(8'h00, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 8'hC8, 8'h64, 1'b1, 1'b1, mk(8'h63, 1'b1, 1'b1, 1'b0));

    // Random sweep on every digit width in parallel.
    fork
      drive_rand(0, 1000);
      drive_rand(1, 1000);
      drive_rand(2, 1000);
      drive_rand(3, 1000);
    join

    for (int t = 0; t < 100; t++) begin
      pend = 0;
      for (int i = 0; i < NI; i++) pend += q[i].size();
      if (pend == 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) check($sformatf("drain[%0d]", i), q[i].size(), 0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
